cjtag_oscan1_bridge: RTL and testbench
======================================

// Module: cjtag_oscan1_bridge
// PURPOSE
//  Target-side cJTAG (IEEE 1149.7 OScan1) to 4-wire JTAG bridge for the debug path.
//  Oversamples the host's TCKC/TMSC pins on the system clock and recognises escape
//  sequences (deselect, select, reset) and the 12-bit activation packet.
//  Once online, it decodes the 3-bit OScan1 scan packets into TCK/TMS/TDI for the
//  internal DTM TAP, and returns TDO on TMSC in each packet's third bit slot.
// PARAMETERS
//  SYNC_STAGES  2  flip-flops in the TCKC/TMSC input synchronisers (2..3)
//  ESC_CNT_W    4  width of the escape toggle counter; saturates at all-ones
// PORTS
//  CLK        in   1  system clock; must be >= 8x the TCKC frequency
//  RES_SYS    in   1  asynchronous active-high reset
//  TCKC_I     in   1  cJTAG clock pin (asynchronous to CLK)
//  TMSC_I     in   1  cJTAG data pin input (asynchronous to CLK)
//  TMSC_O     out  1  TMSC output level
//  TMSC_E     out  1  TMSC output enable (1 = drive)
//  TCK        out  1  JTAG clock to DTM TAP
//  TMS        out  1  JTAG TMS to DTM TAP
//  TDI        out  1  JTAG TDI to DTM TAP
//  TDO        in   1  JTAG TDO from DTM TAP
//  ONLINE     out  1  OScan1 active (status)
// BEHAVIOUR
//  Reset (asynchronous): state=OFFLINE, TCK=0, TMS=1, TDI=1, TMSC_O=0, TMSC_E=0,
//   ONLINE=0, escape counter=0, activation shift register=0, synchronisers=0.
//  Synchronisers: tckc_s and tmsc_s are the SYNC_STAGES-deep synchronised inputs.
//   One extra register per signal gives edge detects: tck_rise, tck_fall, tms_tog.
//   The sampled value is tmsc_s in the same cycle as tck_rise.
//  Escape detection runs in every state and takes priority over packet decoding:
//   - Counter clears on tck_rise and increments (saturating) on each tms_tog while
//     tckc_s=1.
//   - It is evaluated on tck_fall. If the count is 0..3 this is an ordinary bit.
//     4..5 = deselect: go to OFFLINE. 6..7 = select: go to ACT and clear bit_idx.
//     >=8 = reset: go to OFFLINE and force TMS=1 (TAP reset path).
//   - Any escape also forces TCK=0 and TMSC_E=0 on the next cycle.
//  States and transitions:
//   OFFLINE: TMSC_E=0, TCK=0. Ignores tck_rise. Leaves only by a select escape.
//   ACT: on each tck_rise, shift tmsc_s into a 12-bit register, first bit at index 0.
//    On the 12th bit, compare with the sequence 1,1,0,0 (OAC), 1,0,0,0 (EC),
//    0,0,0,0 (CP) in arrival order.
//    Match: go to B0 and set ONLINE=1. Mismatch: go to OFFLINE.
//   B0: on tck_rise, TDI <= ~tmsc_s (nTDI slot); go to B1.
//   B1: on tck_rise, TMS <= tmsc_s; go to B1D.
//   B1D: on tck_fall, TMSC_E <= 1 and TMSC_O <= TDO; go to B2.
//   B2: on tck_rise, TCK <= 1. On the following tck_fall (non-escape), TCK <= 0,
//    TMSC_E <= 0, go to B0.
//   While TMSC_E=1, TMSC_O follows TDO one CLK after a change.
//  Latency: pin edge to TCK/TMSC_E change = SYNC_STAGES+1 CLK cycles.
//  Boundary conditions:
//   - Escape during B2: TCK drops and no further TCK pulse occurs. The TAP sees a
//     complete pulse only if the rise had already happened.
//   - A select escape while ONLINE restarts activation; ONLINE=0 until it matches.
//   - Toggles while TCKC is low do not count. A counter that saturates stays a reset.
//   - tck_rise and tck_fall in the same CLK cycle cannot occur; this is guaranteed by
//     the 8x oversampling rule.
//   - Asserting RES_SYS mid-packet returns all outputs to reset values immediately.
// TESTING
//  T1: reset, then 7 TMSC toggles with TCKC high, then activation bits
//   110010000000 -> ONLINE=1, state B0.
//  T2: online; send packets (nTDI,TMS) = (0,1), (1,0) with TDO=1 then 0 -> TCK pulses
//   twice with TDI/TMS = 1/1 then 0/0; TMSC_O=1 then 0 in bit2 with TMSC_E=1.
//  T3: activation bits 110010000001 -> OFFLINE, ONLINE=0, no TCK pulses thereafter.
//  T4: online; 5 toggles with TCKC high mid-B1 -> OFFLINE, ONLINE=0, TMSC_E=0 within
//   SYNC_STAGES+2 CLK.
//  T5: 10 toggles (reset escape) during B2 after TCK rise -> TCK=0, TMS=1, OFFLINE.
//  T6: assert RES_SYS while TMSC_E=1 -> TMSC_E=0, TCK=0, TMS=1 in the same cycle.

Source files
------------

// File: rtl/cjtag_oscan1_bridge_if.sv
// Pin-level bundle between a cJTAG host, the OScan1 bridge and the DTM TAP.
// The master side drives the cJTAG pins and TDO; the bridge (slave) drives the rest.
interface cjtag_oscan1_bridge_if;
    logic TCKC_I;
    logic TMSC_I;
    logic TMSC_O;
    logic TMSC_E;
    logic TCK;
    logic TMS;
    logic TDI;
    logic TDO;
    logic ONLINE;

    modport master (
        output TCKC_I, TMSC_I, TDO,
        input  TMSC_O, TMSC_E, TCK, TMS, TDI, ONLINE
    );

    modport slave (
        input  TCKC_I, TMSC_I, TDO,
        output TMSC_O, TMSC_E, TCK, TMS, TDI, ONLINE
    );
endinterface

// File: rtl/cjtag_oscan1_bridge.sv
// Target-side cJTAG OScan1 to 4-wire JTAG bridge: oversamples TCKC/TMSC, detects
// escapes and the activation packet, then turns 3-bit scan packets into TCK/TMS/TDI.
module cjtag_oscan1_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int ESC_CNT_W   = 4
) (
    input logic                  CLK,
    input logic                  RES_SYS,
    cjtag_oscan1_bridge_if.slave bus
);

    localparam logic [2:0] ST_OFFLINE = 3'd0;
    localparam logic [2:0] ST_ACT     = 3'd1;
    localparam logic [2:0] ST_B0      = 3'd2;
    localparam logic [2:0] ST_B1      = 3'd3;
    localparam logic [2:0] ST_B1D     = 3'd4;
    localparam logic [2:0] ST_B2      = 3'd5;

    // OAC 1100, EC 1000, CP 0000 in arrival order; first bit lands at index 0.
    localparam logic [11:0] ACT_SEQ = 12'b0000_0001_0011;

    typedef enum logic [1:0] {
        ESC_NONE,
        ESC_DESELECT,
        ESC_SELECT,
        ESC_RESET
    } esc_kind_t;

    logic [SYNC_STAGES-1:0] tckc_sync;
    logic [SYNC_STAGES-1:0] tmsc_sync;
    logic                   tckc_s;
    logic                   tmsc_s;
    logic                   tckc_d;
    logic                   tmsc_d;
    logic                   tck_rise;
    logic                   tck_fall;
    logic                   tms_tog;

    logic [ESC_CNT_W-1:0]   esc_cnt;
    logic [31:0]            esc_val;
    esc_kind_t              esc_kind;

    logic [2:0]             state;
    logic [3:0]             bit_idx;
    logic [11:0]            act_sr;
    logic                   tck_q;
    logic                   tms_q;
    logic                   tdi_q;
    logic                   tmsc_o_q;
    logic                   tmsc_e_q;
    logic                   online_q;

    // NOTE: every flop is updated with <= so all state advances from the same
    // pre-edge values; mixing in blocking assignments makes results order-dependent.
    always_ff @(posedge CLK or posedge RES_SYS) begin
        if (RES_SYS) begin
            tckc_sync <= '0;
            tmsc_sync <= '0;
            tckc_d    <= 1'b0;
            tmsc_d    <= 1'b0;
        end else begin
            tckc_sync <= {tckc_sync[SYNC_STAGES-2:0], bus.TCKC_I};
            tmsc_sync <= {tmsc_sync[SYNC_STAGES-2:0], bus.TMSC_I};
            tckc_d    <= tckc_s;
            tmsc_d    <= tmsc_s;
        end
    end

    assign tckc_s   = tckc_sync[SYNC_STAGES-1];
    assign tmsc_s   = tmsc_sync[SYNC_STAGES-1];
    assign tck_rise = tckc_s & ~tckc_d;
    assign tck_fall = ~tckc_s & tckc_d;
    assign tms_tog  = tmsc_s ^ tmsc_d;

    // Counts TMSC toggles within one TCKC-high phase; saturates so long bursts stay resets.
    always_ff @(posedge CLK or posedge RES_SYS) begin
        if (RES_SYS) begin
            esc_cnt <= '0;
        end else if (tck_rise) begin
            esc_cnt <= '0;
        end else if (tms_tog && tckc_s && (esc_cnt != '1)) begin
            esc_cnt <= esc_cnt + 1'b1;
        end
    end

    assign esc_val = 32'(esc_cnt);

    // NOTE: esc_kind gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        esc_kind = ESC_NONE;
        if (tck_fall) begin
            if (esc_val >= 32'd8) begin
                esc_kind = ESC_RESET;
            end else if (esc_val >= 32'd6) begin
                esc_kind = ESC_SELECT;
            end else if (esc_val >= 32'd4) begin
                esc_kind = ESC_DESELECT;
            end
        end
    end

    always_ff @(posedge CLK or posedge RES_SYS) begin
        if (RES_SYS) begin
            state    <= ST_OFFLINE;
            bit_idx  <= 4'd0;
            act_sr   <= 12'd0;
            tck_q    <= 1'b0;
            tms_q    <= 1'b1;
            tdi_q    <= 1'b1;
            tmsc_o_q <= 1'b0;
            tmsc_e_q <= 1'b0;
            online_q <= 1'b0;
        end else begin
            if (tmsc_e_q) begin
                tmsc_o_q <= bus.TDO;
            end

            if (esc_kind != ESC_NONE) begin
                // An escape always wins: release TMSC and drop TCK whatever the slot.
                tck_q    <= 1'b0;
                tmsc_e_q <= 1'b0;
                online_q <= 1'b0;
                case (esc_kind)
                    ESC_SELECT: begin
                        state   <= ST_ACT;
                        bit_idx <= 4'd0;
                    end
                    ESC_RESET: begin
                        state <= ST_OFFLINE;
                        tms_q <= 1'b1;
                    end
                    default: begin
                        state <= ST_OFFLINE;
                    end
                endcase
            end else begin
                case (state)
                    ST_OFFLINE: begin
                        tck_q    <= 1'b0;
                        tmsc_e_q <= 1'b0;
                    end

                    ST_ACT: begin
                        if (tck_rise) begin
                            act_sr[bit_idx] <= tmsc_s;
                            if (bit_idx == 4'd11) begin
                                bit_idx <= 4'd0;
                                if ({tmsc_s, act_sr[10:0]} == ACT_SEQ) begin
                                    state    <= ST_B0;
                                    online_q <= 1'b1;
                                end else begin
                                    state <= ST_OFFLINE;
                                end
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                            end
                        end
                    end

                    ST_B0: begin
                        if (tck_rise) begin
                            tdi_q <= ~tmsc_s;
                            state <= ST_B1;
                        end
                    end

                    ST_B1: begin
                        if (tck_rise) begin
                            tms_q <= tmsc_s;
                            state <= ST_B1D;
                        end
                    end

                    ST_B1D: begin
                        if (tck_fall) begin
                            tmsc_e_q <= 1'b1;
                            tmsc_o_q <= bus.TDO;
                            state    <= ST_B2;
                        end
                    end

                    ST_B2: begin
                        if (tck_rise) begin
                            tck_q <= 1'b1;
                        end else if (tck_fall) begin
                            tck_q    <= 1'b0;
                            tmsc_e_q <= 1'b0;
                            state    <= ST_B0;
                        end
                    end

                    default: begin
                        state <= ST_OFFLINE;
                    end
                endcase
            end
        end
    end

    assign bus.TCK    = tck_q;
    assign bus.TMS    = tms_q;
    assign bus.TDI    = tdi_q;
    assign bus.TMSC_O = tmsc_o_q;
    assign bus.TMSC_E = tmsc_e_q;
    assign bus.ONLINE = online_q;

endmodule

// File: tb/tb_cjtag_oscan1_bridge.sv
// Self-checking bench for cjtag_oscan1_bridge: drives OScan1 pin waveforms and
// scores every TCK pulse against expected TDI/TMS/TMSC values queued at stimulus time.
module tb_cjtag_oscan1_bridge;

    localparam int S = 2;

    typedef struct packed {
        logic tdi;
        logic tms;
        logic tmsc_o;
        logic tmsc_e;
    } pkt_t;

    logic CLK = 1'b0;
    logic RES_SYS;
    int   n_cmp = 0;
    int   n_err = 0;
    int   tck_pulses = 0;
    int   exp_pulses = 0;
    logic tck_prev = 1'b0;
    pkt_t exp_q[$];

    always #5 CLK = ~CLK;

    cjtag_oscan1_bridge_if bus ();

    cjtag_oscan1_bridge #(
        .SYNC_STAGES(S),
        .ESC_CNT_W  (4)
    ) dut (
        .CLK    (CLK),
        .RES_SYS(RES_SYS),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: each TCK rising edge pops one expected packet.
    always @(negedge CLK) begin
        pkt_t e;
        if (bus.TCK === 1'b1 && tck_prev === 1'b0) begin
            tck_pulses++;
            if (exp_q.size() == 0) begin
                check("tck_unexpected", 32'(bus.TCK), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pkt_tdi_tms_tmsco_tmsce",
                      32'({bus.TDI, bus.TMS, bus.TMSC_O, bus.TMSC_E}), 32'(e));
            end
        end
        tck_prev = bus.TCK;
    end

    task automatic clk_n(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic bit_send(input logic v);
        bus.TMSC_I = v;
        clk_n(4);
        bus.TCKC_I = 1'b1;
        clk_n(8);
        bus.TCKC_I = 1'b0;
        clk_n(4);
    endtask

    // Raises TCKC (if low), toggles TMSC n times, then drops TCKC; caller waits.
    task automatic escape(input int n);
        bus.TCKC_I = 1'b1;
        clk_n(6);
        repeat (n) begin
            bus.TMSC_I = ~bus.TMSC_I;
            clk_n(4);
        end
        bus.TCKC_I = 1'b0;
    endtask

    task automatic activate(input logic [0:11] seq);
        escape(7);
        clk_n(S + 2);
        for (int i = 0; i < 12; i++) bit_send(seq[i]);
    endtask

    // Sends nTDI and TMS slots, then leaves TCKC high inside the TDO slot.
    task automatic packet(input logic ntdi, input logic tms, input logic tdo, input logic expect_pulse);
        pkt_t p;
        bus.TDO = tdo;
        bit_send(ntdi);
        bit_send(tms);
        if (expect_pulse) begin
            p = '{tdi: ~ntdi, tms: tms, tmsc_o: tdo, tmsc_e: 1'b1};
            exp_q.push_back(p);
            exp_pulses++;
        end
        clk_n(4);
        bus.TCKC_I = 1'b1;
        clk_n(8);
    endtask

    task automatic finish_bit2();
        bus.TCKC_I = 1'b0;
        clk_n(8);
    endtask

    initial begin
        RES_SYS    = 1'b1;
        bus.TCKC_I = 1'b0;
        bus.TMSC_I = 1'b0;
        bus.TDO    = 1'b0;
        clk_n(3);
        check("reset_outs", 32'({bus.TCK, bus.TMS, bus.TDI, bus.TMSC_O, bus.TMSC_E, bus.ONLINE}),
              32'(6'b011000));
        RES_SYS = 1'b0;
        clk_n(4);

        // T1: select escape then the activation packet.
        escape(7);
        clk_n(S + 2);
        check("t1_online_before_act", 32'(bus.ONLINE), 32'd0);
        for (int i = 0; i < 12; i++) begin
            logic [0:11] seq;
            seq = 12'b110010000000;
            bit_send(seq[i]);
        end
        check("t1_online", 32'(bus.ONLINE), 32'd1);
        check("t1_tmsc_e_idle", 32'(bus.TMSC_E), 32'd0);

        // T2: two scan packets.
        packet(1'b0, 1'b1, 1'b1, 1'b1);
        finish_bit2();
        check("t2_p1_tck_low", 32'(bus.TCK), 32'd0);
        check("t2_p1_tmsc_e_off", 32'(bus.TMSC_E), 32'd0);
        packet(1'b1, 1'b0, 1'b0, 1'b1);
        bus.TDO = 1'b1;
        clk_n(2);
        check("t2_tmsc_o_follows_tdo", 32'(bus.TMSC_O), 32'd1);
        finish_bit2();
        check("t2_tdi_tms_after", 32'({bus.TDI, bus.TMS}), 32'd0);
        check("t2_pulses", 32'(tck_pulses), 32'(exp_pulses));

        // T3: select while online, then a bad activation packet.
        escape(7);
        clk_n(S + 2);
        check("t3_online_dropped", 32'(bus.ONLINE), 32'd0);
        for (int i = 0; i < 12; i++) begin
            logic [0:11] seq;
            seq = 12'b110010000001;
            bit_send(seq[i]);
        end
        check("t3_online_bad_act", 32'(bus.ONLINE), 32'd0);
        packet(1'b0, 1'b1, 1'b1, 1'b0);
        finish_bit2();
        check("t3_no_tmsc_e", 32'(bus.TMSC_E), 32'd0);
        check("t3_pulses", 32'(tck_pulses), 32'(exp_pulses));

        // T4: deselect escape with TCKC high in the TMS slot.
        activate(12'b110010000000);
        check("t4_online", 32'(bus.ONLINE), 32'd1);
        bit_send(1'b0);
        escape(5);
        clk_n(S + 2);
        check("t4_deselect", 32'({bus.ONLINE, bus.TMSC_E, bus.TCK}), 32'd0);

        // T5: reset escape after TCK has risen in the TDO slot.
        activate(12'b110010000000);
        packet(1'b1, 1'b0, 1'b1, 1'b1);
        check("t5_tck_high", 32'(bus.TCK), 32'd1);
        escape(10);
        clk_n(S + 2);
        check("t5_reset_esc", 32'({bus.TCK, bus.TMS, bus.ONLINE, bus.TMSC_E}), 32'(4'b0100));

        // Saturated escape counter still counts as a reset escape.
        activate(12'b110010000000);
        packet(1'b1, 1'b0, 1'b0, 1'b1);
        finish_bit2();
        check("sat_tms_low", 32'(bus.TMS), 32'd0);
        escape(20);
        clk_n(S + 2);
        check("sat_reset_esc", 32'({bus.TMS, bus.ONLINE}), 32'(2'b10));

        // T6: asynchronous reset while TMSC is driven.
        activate(12'b110010000000);
        bus.TDO = 1'b1;
        bit_send(1'b1);
        bit_send(1'b0);
        check("t6_pre_state", 32'({bus.TMSC_E, bus.TMS, bus.TMSC_O}), 32'(3'b101));
        RES_SYS = 1'b1;
        #1;
        check("t6_async_reset", 32'({bus.TCK, bus.TMS, bus.TDI, bus.TMSC_O, bus.TMSC_E, bus.ONLINE}),
              32'(6'b011000));
        clk_n(2);
        RES_SYS = 1'b0;
        clk_n(2);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("total_pulses", 32'(tck_pulses), 32'(exp_pulses));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
